// File: rtl/trace_capture_pkg.sv
// Shared instruction-field widths plus the trace record layout used by the capture block.
package trace_capture_pkg;

    localparam int unsigned OPCODE_WIDTH = 7;
    localparam int unsigned VALUE_WIDTH  = 32;
    localparam int unsigned MEM_WIDTH    = 16;

    typedef enum logic {
        StIdle,
        StSend
    } ser_state_e;

    // Field order matches the serialized byte order: op_code leaves first.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] op_code;
        logic [1:0]              dest_choice;
        logic [MEM_WIDTH-1:0]    dest_addr;
        logic [VALUE_WIDTH-1:0]  alu_out;
    } trace_rec_t;

    function automatic int unsigned trace_bytes(input int unsigned rec_w);
        return (rec_w + 7) / 8;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record buffer for trace_capture: power-of-two depth, guarded push/pop, occupancy count.
module trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    // Fullness is judged on the start-of-cycle level, so a same-cycle pop never frees a slot.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/trace_capture.sv
// Captures retired-instruction records into a FIFO and streams them out MSB byte first.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned OP_W       = OPCODE_WIDTH,
    parameter int unsigned VAL_W      = VALUE_WIDTH,
    parameter int unsigned ADDR_W     = MEM_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_capture_en,
    input  logic                          i_trace_valid,
    input  logic [OP_W-1:0]               i_op_code,
    input  logic [VAL_W-1:0]              i_alu_out,
    input  logic [ADDR_W-1:0]             i_dest_addr,
    input  logic [1:0]                    i_dest_choice,
    input  logic                          i_clr_overflow,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_last,
    output logic                          o_overflow,
    output logic [7:0]                    o_drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned REC_W   = OP_W + 2 + ADDR_W + VAL_W;
    localparam int unsigned T_BYTES = trace_bytes(REC_W);
    localparam int unsigned BUF_W   = T_BYTES * 8;
    localparam int unsigned IDX_W   = (T_BYTES > 1) ? $clog2(T_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(T_BYTES - 1);

    ser_state_e       r_state;
    ser_state_e       w_state_next;
    logic [BUF_W-1:0] r_shift;
    logic [IDX_W-1:0] r_byte_idx;
    logic             r_overflow;
    logic [7:0]       r_drop_count;

    logic [BUF_W-1:0] w_rec;
    logic [BUF_W-1:0] w_fifo_data;
    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_pop;
    logic             w_advance;
    logic             w_is_last;

    assign w_rec    = BUF_W'({i_op_code, i_dest_choice, i_dest_addr, i_alu_out});
    assign w_accept = i_trace_valid & i_capture_en;
    assign w_drop   = w_accept & w_full;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUF_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (w_rec),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign w_is_last = (r_byte_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (i_tx_ready) begin
                    // Chain straight into the next record to avoid an idle bubble.
                    if (w_is_last) begin
                        if (!w_empty) w_pop = 1'b1;
                        else          w_state_next = StIdle;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_byte_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_shift    <= w_fifo_data;
                r_byte_idx <= '0;
            end else if (w_advance) begin
                r_shift    <= r_shift << 8;
                r_byte_idx <= r_byte_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            if (i_clr_overflow)            r_drop_count <= 8'd1;
            else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end else if (i_clr_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign o_tx_valid   = (r_state == StSend);
    assign o_tx_data    = o_tx_valid ? r_shift[BUF_W-1 -: 8] : 8'h00;
    assign o_tx_last    = o_tx_valid & w_is_last;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_trace_capture.sv
// Randomized and directed bench for trace_capture, checked every cycle against a queue model.
module tb_trace_capture;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       capture_en;
    logic       trace_valid;
    logic [5:0] op;
    logic [7:0] alu;
    logic [7:0] addr;
    logic [1:0] choice;
    logic       clr;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       overflow;
    logic [7:0] drop_count;
    logic [3:0] fifo_level;

    int n_vec = 0;
    int n_err = 0;

    trace_capture #(
        .FIFO_DEPTH (DEPTH),
        .OP_W       (6),
        .VAL_W      (8),
        .ADDR_W     (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_capture_en   (capture_en),
        .i_trace_valid  (trace_valid),
        .i_op_code      (op),
        .i_alu_out      (alu),
        .i_dest_addr    (addr),
        .i_dest_choice  (choice),
        .i_clr_overflow (clr),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_tx_data      (tx_data),
        .o_tx_last      (tx_last),
        .o_overflow     (overflow),
        .o_drop_count   (drop_count),
        .o_fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of buffered records, the record on the wire and how many bytes remain.
    logic [23:0] m_q[$];
    logic [23:0] m_cur;
    int          m_rem;
    logic        m_ovf;
    int          m_drop;
    int          m_sz;
    logic        m_hs;
    logic        m_acc;
    logic        m_pop;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_rem  = 0;
            m_cur  = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_hs  = (m_rem > 0) && tx_ready;
            m_sz  = m_q.size();
            m_acc = trace_valid && capture_en;
            m_pop = (m_sz > 0) && ((m_rem == 0) || (m_hs && m_rem == 1));
            if (m_hs) m_rem--;
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_rem = 3;
            end
            if (m_acc && m_sz < DEPTH) m_q.push_back({op, choice, addr, alu});
            if (m_acc && m_sz >= DEPTH) begin
                m_ovf  = 1'b1;
                m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        #1;
        chk("tx_valid", tx_valid, m_rem > 0);
        chk("tx_last", tx_last, m_rem == 1);
        if (m_rem > 0) chk("tx_data", tx_data, m_cur[m_rem*8-1 -: 8]);
        chk("fifo_level", fifo_level, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drop);
    end

    task automatic push_rec(input logic [5:0] o, input logic [1:0] c,
                            input logic [7:0] a, input logic [7:0] v);
        trace_valid = 1'b1;
        op          = o;
        choice      = c;
        addr        = a;
        alu         = v;
        @(negedge clk);
        trace_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        int i = 0;
        while (!tx_valid && i < max_cycles) begin
            @(negedge clk);
            i++;
        end
        chk("wait_valid", tx_valid, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        capture_en  = 1'b1;
        trace_valid = 1'b0;
        op          = '0;
        alu         = '0;
        addr        = '0;
        choice      = '0;
        clr         = 1'b0;
        tx_ready    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_last", tx_last, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drops", drop_count, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single record, ready held high.
        push_rec(6'h05, 2'd2, 8'h1A, 8'h3C);
        chk("lat_not_yet", tx_valid, 1'b0);
        @(negedge clk);
        chk("b0_valid", tx_valid, 1'b1);
        chk("b0_data", tx_data, 8'h16);
        chk("b0_last", tx_last, 1'b0);
        @(negedge clk);
        chk("b1_data", tx_data, 8'h1A);
        chk("b1_last", tx_last, 1'b0);
        @(negedge clk);
        chk("b2_data", tx_data, 8'h3C);
        chk("b2_last", tx_last, 1'b1);
        @(negedge clk);
        chk("single_done", tx_valid, 1'b0);

        // Two records back to back stream without a bubble.
        push_rec(6'h11, 2'd1, 8'h22, 8'h33);
        push_rec(6'h2A, 2'd3, 8'h44, 8'h55);
        wait_valid(4);
        for (int i = 0; i < 6; i++) begin
            chk("b2b_valid", tx_valid, 1'b1);
            @(negedge clk);
        end
        chk("b2b_done", tx_valid, 1'b0);

        // Backpressure holds the first byte.
        tx_ready = 1'b0;
        push_rec(6'h05, 2'd2, 8'h1A, 8'h3C);
        wait_valid(4);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", tx_valid, 1'b1);
            chk("stall_data", tx_data, 8'h16);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);

        // Serializer already holds a record, so 10 pushes leave 8 buffered and 2 dropped.
        tx_ready = 1'b0;
        push_rec(6'h3F, 2'd0, 8'hEE, 8'hDD);
        wait_valid(4);
        for (int i = 0; i < 10; i++) push_rec(6'(i), 2'(i), 8'(8'h80 + i), 8'(8'hA0 + i));
        chk("ovf_level", fifo_level, 4'd8);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", drop_count, 8'd2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_flag", overflow, 1'b0);
        chk("clr_drops", drop_count, 8'd0);
        tx_ready = 1'b1;
        repeat (32) @(negedge clk);
        chk("drain_level", fifo_level, 4'd0);

        // Reset in the middle of a record.
        push_rec(6'h05, 2'd2, 8'h1A, 8'h3C);
        push_rec(6'h06, 2'd1, 8'h10, 8'h20);
        wait_valid(4);
        @(negedge clk);
        chk("pre_rst_byte", tx_data, 8'h1A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_level", fifo_level, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", tx_valid, 1'b0);
        end

        // Capture disabled: trace pulses are ignored.
        capture_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_rec(6'h01, 2'd0, 8'h02, 8'h03);
            @(negedge clk);
        end
        chk("dis_level", fifo_level, 4'd0);
        chk("dis_drops", drop_count, 8'd0);
        capture_en = 1'b1;

        // Random traffic, including capture_en toggles and occasional clears.
        for (int i = 0; i < 1500; i++) begin
            capture_en  = ($urandom_range(0, 7) != 0);
            trace_valid = $urandom_range(0, 1);
            tx_ready    = $urandom_range(0, 1);
            clr         = ($urandom_range(0, 31) == 0);
            op          = 6'($urandom);
            alu         = 8'($urandom);
            addr        = 8'($urandom);
            choice      = 2'($urandom);
            @(negedge clk);
        end
        trace_valid = 1'b0;
        clr         = 1'b0;
        tx_ready    = 1'b1;
        repeat (40) @(negedge clk);

        // Saturate the drop counter, then clear coinciding with a drop.
        tx_ready    = 1'b0;
        trace_valid = 1'b1;
        for (int i = 0; i < 275; i++) begin
            alu = 8'($urandom);
            @(negedge clk);
        end
        chk("sat_drops", drop_count, 8'd255);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_vs_drop_flag", overflow, 1'b1);
        chk("clr_vs_drop_cnt", drop_count, 8'd1);
        trace_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_only_cnt", drop_count, 8'd0);
        tx_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
